// File: rtl/reg_dump_engine.sv
// Debug read-out engine: walks every register-file address through one read port and
// streams each word out on a valid/ready channel. Define REG_DUMP_CHECKSUM_EN to append an XOR checksum beat.
module reg_dump_engine #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              sysclk,
    input  logic              sys_rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_SEND,
        S_CSUM,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic              is_last;
    logic              accept;

`ifdef REG_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csum;
`endif

    // idx is parked at 0 outside a dump, so it can drive the read port directly.
    assign rd_addr = idx;
    assign is_last = (idx == LAST_IDX);
    assign accept  = out_valid && out_ready;

    // NOTE: every state register uses <= so all updates land together at the edge,
    // independent of statement order inside the block.
    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= S_READ;
`ifdef REG_DUMP_CHECKSUM_EN
                        csum  <= '0;
`endif
                    end
                end
                S_READ: begin
                    out_data  <= rd_data;
                    out_index <= idx;
                    out_valid <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                    out_last  <= 1'b0;
                    csum      <= csum ^ rd_data;
`else
                    out_last  <= is_last;
`endif
                    state     <= S_SEND;
                end
                S_SEND: begin
                    if (accept) begin
                        out_valid <= 1'b0;
                        if (is_last) begin
`ifdef REG_DUMP_CHECKSUM_EN
                            // Checksum beat goes out back-to-back with the last register.
                            out_valid <= 1'b1;
                            out_data  <= csum;
                            out_index <= '0;
                            out_last  <= 1'b1;
                            state     <= S_CSUM;
`else
                            idx   <= '0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
`endif
                        end else begin
                            idx   <= idx + ADDR_W'(1);
                            state <= S_READ;
                        end
                    end
                end
                S_CSUM: begin
                    if (accept) begin
                        out_valid <= 1'b0;
                        idx       <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_engine.sv
// Directed bench for reg_dump_engine: full dump, backpressure, ignored start, mid-dump reset.
// Works with or without REG_DUMP_CHECKSUM_EN defined.
module tb_reg_dump_engine;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
`ifdef REG_DUMP_CHECKSUM_EN
    localparam int NUM_BEATS = NUM_REGS + 1;
    localparam int DONE_LAT  = 66;
`else
    localparam int NUM_BEATS = NUM_REGS;
    localparam int DONE_LAT  = 65;
`endif

    typedef struct packed {
        logic              last;
        logic [ADDR_W-1:0] index;
        logic [DATA_W-1:0] data;
    } beat_t;

    logic              sysclk    = 1'b0;
    logic              sys_rst_n = 1'b0;
    logic              start     = 1'b0;
    logic              out_ready = 1'b0;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_index;
    logic              out_last;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] regs [NUM_REGS];

    int    tests_run        = 0;
    int    tests_failed     = 0;
    int    edge_cnt         = 0;
    int    done_cnt         = 0;
    int    done_edge        = 0;
    int    first_valid_edge = -1;
    int    e0;
    beat_t beat_q [$];

    reg_dump_engine #(
        .NUM_REGS(NUM_REGS),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .sysclk   (sysclk),
        .sys_rst_n(sys_rst_n),
        .start    (start),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_index(out_index),
        .out_last (out_last),
        .busy     (busy),
        .done     (done)
    );

    always #5 sysclk = ~sysclk;

    assign rd_data = regs[rd_addr];

    always @(posedge sysclk) edge_cnt <= edge_cnt + 1;

    // Beat/done monitor, sampled mid-cycle while inputs and outputs are stable.
    always @(negedge sysclk) begin
        if (out_valid && out_ready) beat_q.push_back({out_last, out_index, out_data});
        if (done) begin
            done_cnt  = done_cnt + 1;
            done_edge = edge_cnt;
        end
        if (out_valid && first_valid_edge < 0) first_valid_edge = edge_cnt;
    end

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        tests_run = tests_run + 1;
        if (actual !== expected) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    function automatic beat_t exp_beat(input int i);
        beat_t b;
        b.index = ADDR_W'(i);
        b.last  = 1'b0;
        case (i)
            1:       b.data = 32'h01234567;
            2:       b.data = 32'hffffffff;
            3:       b.data = 32'h00000001;
            default: b.data = 32'h0;
        endcase
`ifdef REG_DUMP_CHECKSUM_EN
        if (i == NUM_REGS) begin
            b.index = '0;
            b.data  = 32'hfedcba99;
            b.last  = 1'b1;
        end
`else
        b.last = (i == NUM_REGS - 1);
`endif
        return b;
    endfunction

    task automatic step;
        @(posedge sysclk);
        #1;
    endtask

    task automatic pulse_start(output int e);
        e     = edge_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_beats(input int k, input string tag);
        int n = 0;
        while (beat_q.size() < k && n < 400) begin
            step();
            n++;
        end
        check(tag, 64'(beat_q.size() >= k), 64'd1);
    endtask

    task automatic wait_done(input int target, input string tag);
        int n = 0;
        while (done_cnt < target && n < 400) begin
            step();
            n++;
        end
        check(tag, 64'(done_cnt), 64'(target));
    endtask

    task automatic check_dump(input string tag);
        check({tag, "_count"}, 64'(beat_q.size()), 64'(NUM_BEATS));
        for (int i = 0; i < beat_q.size() && i < NUM_BEATS; i++)
            check($sformatf("%s_beat%0d", tag, i), 64'(beat_q[i]), 64'(exp_beat(i)));
    endtask

    task automatic new_dump;
        beat_q.delete();
        done_cnt         = 0;
        first_valid_edge = -1;
    endtask

    initial begin
        for (int i = 0; i < NUM_REGS; i++) regs[i] = '0;
        regs[1] = 32'h01234567;
        regs[2] = 32'hffffffff;
        regs[3] = 32'h00000001;

        // Reset then idle
        repeat (5) @(posedge sysclk);
        #1 sys_rst_n = 1'b1;
        @(negedge sysclk);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_addr", 64'(rd_addr), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_outs", 64'({out_last, out_index, out_data}), 64'd0);
        step();

        // Full dump with a second start issued mid-dump
        out_ready = 1'b1;
        new_dump();
        pulse_start(e0);
        check("busy_on", 64'(busy), 64'd1);
        wait_beats(5, "wait_beat5");
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(1, "full_done");
        check("first_valid_lat", 64'(first_valid_edge - e0), 64'd2);
        check("done_lat", 64'(done_edge - e0), 64'(DONE_LAT));
        repeat (4) step();
        check("one_done", 64'(done_cnt), 64'd1);
        check("idle_after", 64'({busy, out_valid, done}), 64'd0);
        check_dump("full");

        // Backpressure on the index-2 beat
        new_dump();
        pulse_start(e0);
        wait_beats(2, "wait_beat2");
        out_ready = 1'b0;
        step();
        for (int c = 0; c < 10; c++) begin
            @(negedge sysclk);
            check($sformatf("hold_c%0d", c), 64'({out_valid, out_index, out_data}),
                  64'({1'b1, 5'd2, 32'hffffffff}));
            step();
        end
        out_ready = 1'b1;
        wait_done(1, "bp_done");
        check_dump("bp");

        // Reset during the index-10 SEND
        new_dump();
        pulse_start(e0);
        wait_beats(10, "wait_beat10");
        out_ready = 1'b0;
        step();
        check("pre_abort", 64'({out_valid, busy, out_index}), 64'({1'b1, 1'b1, 5'd10}));
        sys_rst_n = 1'b0;
        #1;
        check("abort_outs", 64'({out_valid, busy, rd_addr, out_index}), 64'd0);
        repeat (2) step();
        sys_rst_n = 1'b1;
        repeat (3) step();
        check("abort_no_done", 64'(done_cnt), 64'd0);

        // Restart after abort
        new_dump();
        out_ready = 1'b1;
        pulse_start(e0);
        wait_done(1, "restart_done");
        check_dump("restart");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
